// File: rtl/actuator_chain_pkg.sv
// Shared encodings for the actuator chain sequencer: FSM states,
// per-stage position sensor codes and latched fault codes.
package actuator_chain_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_IDLE     = 3'b001,
        ST_MOVE_FWD = 3'b010,
        ST_MOVE_BWD = 3'b011,
        ST_STOP     = 3'b100,
        ST_FAULT    = 3'b101
    } state_t;

    localparam logic [1:0] POS_HOME = 2'b00;
    localparam logic [1:0] POS_END  = 2'b01;
    localparam logic [1:0] POS_MID  = 2'b10;
    localparam logic [1:0] POS_BAD  = 2'b11;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_INCONS  = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;
    localparam logic [1:0] FLT_SENSOR  = 2'b11;

endpackage

// File: rtl/seq_timeout_timer.sv
// Per-stage travel watchdog: counts enabled cycles since the last clear
// and holds expired once the count reaches TIMEOUT_CYCLES-1.
module seq_timeout_timer #(
    parameter int unsigned TMR_W          = 24,
    parameter int unsigned TIMEOUT_CYCLES = 16777215
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/actuator_chain_sequencer.sv
// Deploys/retracts a chain of two-direction actuators in order, with
// travel timeout, sensor/consistency checking and a latched fault.
module actuator_chain_sequencer
    import actuator_chain_pkg::*;
#(
    parameter int unsigned N_STAGES       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16777215,
    parameter int unsigned TMR_W          = 24,
    parameter int unsigned IDX_W          = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pull,
    input  logic                  i_press,
    input  logic                  i_fault_clr,
    input  logic [2*N_STAGES-1:0] i_pos,
    output logic [N_STAGES-1:0]   o_fwd,
    output logic [N_STAGES-1:0]   o_bwd,
    output logic [2:0]            o_state,
    output logic [IDX_W-1:0]      o_stage,
    output logic                  o_busy,
    output logic                  o_fault,
    output logic [1:0]            o_fault_code
);

    localparam int unsigned          DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0]     LAST  = IDX_W'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0]  ONE   = N_STAGES'(1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [1:0]       fault_code, code_nx;
    logic             cmd_fwd, cmd_bwd, expired;
    logic             sensor_bad, incons, all_end, above_home;
    logic [IDX_W-1:0] first;
    logic [1:0]       pos_cur;
    logic [1:0]       pos [DEPTH];

    // Pad unused index slots with HOME so pos[idx] is always in range.
    for (genvar g = 0; g < DEPTH; g++) begin : g_pos
        if (g < N_STAGES) begin : g_live
            assign pos[g] = i_pos[2*g +: 2];
        end else begin : g_pad
            assign pos[g] = POS_HOME;
        end
    end

    assign cmd_fwd = i_pull & ~i_press;
    assign cmd_bwd = i_press & ~i_pull;
    assign pos_cur = pos[idx];

    always_comb begin
        sensor_bad = 1'b0;
        incons     = 1'b0;
        all_end    = 1'b1;
        first      = '0;
        above_home = 1'b1;
        for (int unsigned k = 0; k < N_STAGES; k++) begin
            if (pos[IDX_W'(k)] == POS_BAD) sensor_bad = 1'b1;
            if (IDX_W'(k) < idx && pos[IDX_W'(k)] != POS_END) incons = 1'b1;
            if (IDX_W'(k) > idx && pos[IDX_W'(k)] != POS_HOME) incons = 1'b1;
            if (all_end && pos[IDX_W'(k)] != POS_END) begin
                all_end = 1'b0;
                first   = IDX_W'(k);
            end
        end
        for (int unsigned k = 0; k < N_STAGES; k++) begin
            if (IDX_W'(k) > first && pos[IDX_W'(k)] != POS_HOME) above_home = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        code_nx  = fault_code;
        unique case (state)
            ST_INIT: begin
                if (all_end) begin
                    idx_nx   = LAST;
                    state_nx = ST_IDLE;
                end else if (above_home && (pos[first] == POS_HOME || pos[first] == POS_MID)) begin
                    idx_nx   = first;
                    state_nx = (pos[first] == POS_MID) ? ST_STOP : ST_IDLE;
                end else begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_INCONS;
                end
            end
            ST_IDLE, ST_STOP: begin
                if (sensor_bad) begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_SENSOR;
                end else if (incons) begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_INCONS;
                end else if (cmd_fwd) begin
                    if (pos_cur != POS_END) begin
                        state_nx = ST_MOVE_FWD;
                    end else if (idx != LAST) begin
                        idx_nx   = idx + 1'b1;
                        state_nx = ST_MOVE_FWD;
                    end
                end else if (cmd_bwd) begin
                    if (pos_cur != POS_HOME) begin
                        state_nx = ST_MOVE_BWD;
                    end else if (idx != '0) begin
                        idx_nx   = idx - 1'b1;
                        state_nx = ST_MOVE_BWD;
                    end
                end
            end
            ST_MOVE_FWD: begin
                if (sensor_bad) begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_SENSOR;
                end else if (incons) begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_INCONS;
                end else if (pos_cur == POS_END) begin
                    // Arrival wins over a released button: hand off, then park.
                    if (idx == LAST) begin
                        state_nx = ST_IDLE;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        state_nx = cmd_fwd ? ST_MOVE_FWD : ST_STOP;
                    end
                end else if (!cmd_fwd) begin
                    state_nx = ST_STOP;
                end else if (expired) begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_TIMEOUT;
                end
            end
            ST_MOVE_BWD: begin
                if (sensor_bad) begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_SENSOR;
                end else if (incons) begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_INCONS;
                end else if (pos_cur == POS_HOME) begin
                    if (idx == '0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        idx_nx   = idx - 1'b1;
                        state_nx = cmd_bwd ? ST_MOVE_BWD : ST_STOP;
                    end
                end else if (!cmd_bwd) begin
                    state_nx = ST_STOP;
                end else if (expired) begin
                    state_nx = ST_FAULT;
                    code_nx  = FLT_TIMEOUT;
                end
            end
            ST_FAULT: begin
                if (i_fault_clr && !i_pull && !i_press) begin
                    state_nx = ST_INIT;
                    code_nx  = FLT_NONE;
                end
            end
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_INIT;
            idx        <= '0;
            fault_code <= FLT_NONE;
            o_fwd      <= '0;
            o_bwd      <= '0;
            o_busy     <= 1'b0;
            o_fault    <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            fault_code <= code_nx;
            o_fwd      <= (state_nx == ST_MOVE_FWD) ? (ONE << idx_nx) : '0;
            o_bwd      <= (state_nx == ST_MOVE_BWD) ? (ONE << idx_nx) : '0;
            o_busy     <= (state_nx == ST_MOVE_FWD) || (state_nx == ST_MOVE_BWD);
            o_fault    <= (state_nx == ST_FAULT);
        end
    end

    seq_timeout_timer #(
        .TMR_W          (TMR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   ((state_nx != state) || (idx_nx != idx)),
        .enable  ((state == ST_MOVE_FWD) || (state == ST_MOVE_BWD)),
        .expired (expired)
    );

    assign o_state      = state;
    assign o_stage      = idx;
    assign o_fault_code = fault_code;

endmodule

// File: tb/tb_actuator_chain_sequencer.sv
// Scoreboard bench for a two-stage chain with a 16-cycle travel timeout.
module tb_actuator_chain_sequencer;

    localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_MF = 3'd2,
                           S_MB = 3'd3, S_STOP = 3'd4, S_FLT = 3'd5;
    localparam logic [1:0] H = 2'b00, E = 2'b01, M = 2'b10, B = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, pull = 1'b0, press = 1'b0, fclr = 1'b0;
    logic [3:0] pos = '0;
    logic [1:0] o_fwd, o_bwd, o_fault_code;
    logic [2:0] o_state, o_stage;
    logic       o_busy, o_fault;

    typedef struct {
        string      nm;
        logic [2:0] st;
        logic [2:0] stg;
        logic [1:0] fwd;
        logic [1:0] bwd;
        logic       busy;
        logic       fault;
        logic [1:0] code;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    actuator_chain_sequencer #(
        .N_STAGES       (2),
        .TIMEOUT_CYCLES (16),
        .TMR_W          (5),
        .IDX_W          (3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pull       (pull),
        .i_press      (press),
        .i_fault_clr  (fclr),
        .i_pos        (pos),
        .o_fwd        (o_fwd),
        .o_bwd        (o_bwd),
        .o_state      (o_state),
        .o_stage      (o_stage),
        .o_busy       (o_busy),
        .o_fault      (o_fault),
        .o_fault_code (o_fault_code)
    );

    // Drive one cycle of inputs and queue the response due after the next edge.
    task automatic step(input logic r, input logic pl, input logic pr, input logic cl,
                        input logic [1:0] p1, input logic [1:0] p0,
                        input logic [2:0] st, input logic [2:0] stg,
                        input logic [1:0] fwd, input logic [1:0] bwd,
                        input logic [1:0] code, input string nm);
        exp_t x;
        @(negedge clk);
        rst_n = r; pull = pl; press = pr; fclr = cl; pos = {p1, p0};
        x.nm = nm; x.st = st; x.stg = stg; x.fwd = fwd; x.bwd = bwd;
        x.busy = (st == S_MF) || (st == S_MB);
        x.fault = (st == S_FLT);
        x.code = code;
        sbq.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({o_state, o_stage, o_fwd, o_bwd, o_busy, o_fault, o_fault_code} !==
                {e.st, e.stg, e.fwd, e.bwd, e.busy, e.fault, e.code}) begin
                errors++;
                $display("FAIL %s: got st=%0d stg=%0d fwd=%b bwd=%b busy=%b flt=%b code=%b, want st=%0d stg=%0d fwd=%b bwd=%b busy=%b flt=%b code=%b",
                         e.nm, o_state, o_stage, o_fwd, o_bwd, o_busy, o_fault, o_fault_code,
                         e.st, e.stg, e.fwd, e.bwd, e.busy, e.fault, e.code);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //    rst pl pr cl  p1 p0  state  stg fwd    bwd    code
        step(0, 0, 0, 0, H, H, S_INIT, 0, 2'b00, 2'b00, 2'b00, "reset");
        step(1, 0, 0, 0, H, H, S_IDLE, 0, 2'b00, 2'b00, 2'b00, "init_idle");
        // deploy
        step(1, 1, 0, 0, H, H, S_MF,   0, 2'b01, 2'b00, 2'b00, "fwd_start");
        step(1, 1, 0, 0, H, M, S_MF,   0, 2'b01, 2'b00, 2'b00, "fwd_mid0");
        step(1, 1, 0, 0, H, E, S_MF,   1, 2'b10, 2'b00, 2'b00, "fwd_handoff");
        step(1, 1, 0, 0, H, E, S_MF,   1, 2'b10, 2'b00, 2'b00, "fwd_s1");
        step(1, 1, 0, 0, M, E, S_MF,   1, 2'b10, 2'b00, 2'b00, "fwd_mid1");
        step(1, 1, 0, 0, E, E, S_IDLE, 1, 2'b00, 2'b00, 2'b00, "fwd_done");
        step(1, 1, 0, 0, E, E, S_IDLE, 1, 2'b00, 2'b00, 2'b00, "fwd_at_end");
        step(1, 0, 0, 0, E, E, S_IDLE, 1, 2'b00, 2'b00, 2'b00, "idle_end");
        // retract with a pause mid-travel
        step(1, 0, 1, 0, E, E, S_MB,   1, 2'b00, 2'b10, 2'b00, "bwd_start");
        step(1, 0, 1, 0, M, E, S_MB,   1, 2'b00, 2'b10, 2'b00, "bwd_mid1");
        step(1, 0, 0, 0, M, E, S_STOP, 1, 2'b00, 2'b00, 2'b00, "bwd_release");
        step(1, 0, 0, 0, M, E, S_STOP, 1, 2'b00, 2'b00, 2'b00, "stop_hold");
        step(1, 0, 1, 0, M, E, S_MB,   1, 2'b00, 2'b10, 2'b00, "bwd_resume");
        step(1, 0, 1, 0, H, E, S_MB,   0, 2'b00, 2'b01, 2'b00, "bwd_handoff");
        step(1, 0, 1, 0, H, M, S_MB,   0, 2'b00, 2'b01, 2'b00, "bwd_mid0");
        step(1, 0, 1, 0, H, H, S_IDLE, 0, 2'b00, 2'b00, 2'b00, "bwd_done");
        step(1, 0, 1, 0, H, H, S_IDLE, 0, 2'b00, 2'b00, 2'b00, "bwd_at_home");
        // travel timeout: 16 MOVE cycles, then fault
        step(1, 1, 0, 0, H, H, S_MF,   0, 2'b01, 2'b00, 2'b00, "to_start");
        for (int i = 1; i < 16; i++)
            step(1, 1, 0, 0, H, H, S_MF, 0, 2'b01, 2'b00, 2'b00, "to_wait");
        step(1, 1, 0, 0, H, H, S_FLT,  0, 2'b00, 2'b00, 2'b10, "to_fault");
        step(1, 1, 0, 1, H, H, S_FLT,  0, 2'b00, 2'b00, 2'b10, "clr_btn_held");
        step(1, 0, 0, 1, H, H, S_INIT, 0, 2'b00, 2'b00, 2'b00, "clr_to_init");
        step(1, 0, 0, 0, H, H, S_IDLE, 0, 2'b00, 2'b00, 2'b00, "clr_idle");
        // invalid sensor during travel
        step(1, 1, 0, 0, H, H, S_MF,   0, 2'b01, 2'b00, 2'b00, "bad_start");
        step(1, 1, 0, 0, B, H, S_FLT,  0, 2'b00, 2'b00, 2'b11, "bad_sensor");
        // inconsistent chain at start-up
        step(0, 0, 0, 0, E, H, S_INIT, 0, 2'b00, 2'b00, 2'b00, "rst_incons");
        step(1, 0, 0, 0, E, H, S_FLT,  0, 2'b00, 2'b00, 2'b01, "init_incons");
        step(1, 0, 0, 1, H, H, S_INIT, 0, 2'b00, 2'b00, 2'b00, "clr2_init");
        step(1, 0, 0, 0, H, H, S_IDLE, 0, 2'b00, 2'b00, 2'b00, "clr2_idle");
        // both buttons, stray clear, reset mid-motion, parked start-up
        step(1, 1, 0, 0, H, H, S_MF,   0, 2'b01, 2'b00, 2'b00, "both_start");
        step(1, 1, 1, 0, H, M, S_STOP, 0, 2'b00, 2'b00, 2'b00, "both_btn");
        step(1, 0, 0, 1, H, M, S_STOP, 0, 2'b00, 2'b00, 2'b00, "stray_clr");
        step(1, 1, 0, 0, H, M, S_MF,   0, 2'b01, 2'b00, 2'b00, "resume_fwd");
        step(0, 1, 0, 0, H, M, S_INIT, 0, 2'b00, 2'b00, 2'b00, "rst_in_motion");
        step(1, 0, 0, 0, H, M, S_STOP, 0, 2'b00, 2'b00, 2'b00, "init_parked");
        step(1, 0, 0, 0, H, M, S_STOP, 0, 2'b00, 2'b00, 2'b00, "parked_hold");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses never observed, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
